// File: rtl/timer_device.sv
// timer_device -- memory-mapped 32-bit down-counting timer with interrupt.
//
// Register map (word offset on Addr):
//   0 CTRL   [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x one-shot),
//            [3] IM (1 = IRQ allowed), [31:4] read as 0
//   1 PRESET reload value, read/write
//   2 COUNT  current count, read-only
//   3 unused, reads 0, writes ignored
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous, active-high
//   Addr  - register word offset
//   WE    - write enable for the register at Addr
//   Din   - write data
//   Dout  - combinational read data for the register at Addr
//   IRQ   - interrupt request (irq_flag AND CTRL.IM, both registered)
//
// Build option: define TIMER_AUTO_RELOAD_EN to store CTRL.MODE and enable
// auto-reload. Without it MODE is not stored, reads 0, and every expiry
// behaves as one-shot.

module timer_device (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        ctrl_en;
    logic        ctrl_im;
    logic [1:0]  ctrl_mode;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic        auto_reload;

    logic        wr_ctrl, wr_preset;
    logic        count_load, count_dec, expire;
    logic        hw_en_clr, flag_pulse_clr;

    // Din[31:4] never stored; Din[2:1] only stored with auto-reload built in.
    logic        unused_din;
    assign unused_din = ^{Din[31:4], Din[2:1]};

    assign wr_ctrl   = WE && (Addr == 2'd0);
    assign wr_preset = WE && (Addr == 2'd1);

`ifdef TIMER_AUTO_RELOAD_EN
    always_ff @(posedge clk) begin
        if (reset)
            ctrl_mode <= 2'b00;
        else if (wr_ctrl)
            ctrl_mode <= Din[2:1];
    end
    // 1x encodings fall back to one-shot.
    assign auto_reload = (ctrl_mode == 2'b01);
`else
    assign ctrl_mode   = 2'b00;
    assign auto_reload = 1'b0;
`endif

    // Next-state and datapath controls.
    always_comb begin
        state_nxt      = state;
        count_load     = 1'b0;
        count_dec      = 1'b0;
        expire         = 1'b0;
        hw_en_clr      = 1'b0;
        flag_pulse_clr = 1'b0;
        case (state)
            IDLE: if (ctrl_en) state_nxt = LOAD;
            LOAD: begin
                count_load = 1'b1;
                state_nxt  = CNT;
            end
            CNT: begin
                if (!ctrl_en) begin
                    state_nxt = IDLE;
                end else if (count > 32'd1) begin
                    count_dec = 1'b1;
                end else begin
                    // COUNT of 1 or 0 both expire, so COUNT never wraps.
                    expire    = 1'b1;
                    state_nxt = INT;
                end
            end
            INT: begin
                if (auto_reload) begin
                    flag_pulse_clr = 1'b1;
                    state_nxt      = LOAD;
                end else begin
                    hw_en_clr = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A processor CTRL write beats the hardware EN clear on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en <= 1'b0;
            ctrl_im <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en <= Din[0];
            ctrl_im <= Din[3];
        end else if (hw_en_clr) begin
            ctrl_en <= 1'b0;
        end
    end

    // PRESET only reaches COUNT in LOAD, so writes during CNT wait for reload.
    always_ff @(posedge clk) begin
        if (reset)
            preset <= 32'd0;
        else if (wr_preset)
            preset <= Din;
    end

    always_ff @(posedge clk) begin
        if (reset)
            count <= 32'd0;
        else if (count_load)
            count <= preset;
        else if (count_dec)
            count <= count - 32'd1;
        else if (expire)
            count <= 32'd0;
    end

    // Processor acknowledge (CTRL/PRESET write) wins over a same-edge set.
    always_ff @(posedge clk) begin
        if (reset)
            irq_flag <= 1'b0;
        else if (wr_ctrl || wr_preset)
            irq_flag <= 1'b0;
        else if (expire)
            irq_flag <= 1'b1;
        else if (flag_pulse_clr)
            irq_flag <= 1'b0;
    end

    assign IRQ = irq_flag & ctrl_im;

    always_comb begin
        Dout = 32'd0;
        case (Addr)
            2'd0:    Dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
            2'd1:    Dout = preset;
            2'd2:    Dout = count;
            default: Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device -- directed, scoreboard-driven bench for timer_device.
// Expected values are queued as stimulus is driven and popped when the
// corresponding DUT output is sampled (1 ns or more after the rising edge).

module tb_timer_device;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_assert = 0;
    int n_fail   = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    timer_device dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic rd_chk(input string t, input logic [1:0] a, input logic [31:0] e);
        push(t, e);
        Addr = a;
        #1;
        chk(Dout);
    endtask

    task automatic irq_chk(input string t, input logic e);
        push(t, {31'd0, e});
        chk({31'd0, IRQ});
    endtask

    // Poll COUNT until it equals v; a timeout shows up as a failed compare.
    task automatic wait_count(input logic [31:0] v);
        for (int i = 0; i < 200; i++) begin
            Addr = 2'd2;
            #1;
            if (Dout === v) break;
            tick();
        end
        push("wait_count", v);
        Addr = 2'd2;
        #1;
        chk(Dout);
    endtask

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = 2'd0;
        Din   = 32'd0;

        // Reset state
        tick(); tick();
        rd_chk("rst_ctrl",   2'd0, 32'd0);
        rd_chk("rst_preset", 2'd1, 32'd0);
        rd_chk("rst_count",  2'd2, 32'd0);
        rd_chk("rst_addr3",  2'd3, 32'd0);
        irq_chk("rst_irq", 1'b0);
        reset = 1'b0;
        tick();

        // One-shot, PRESET=5, IM=1
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick();                        // -> LOAD
        tick();                        // -> CNT, COUNT=5
        for (int v = 5; v >= 1; v--) begin
            rd_chk("os_count", 2'd2, v[31:0]);
            irq_chk("os_irq_low", 1'b0);
            tick();
        end
        rd_chk("os_count0", 2'd2, 32'd0);
        irq_chk("os_irq_rise", 1'b1);
        tick();
        rd_chk("os_ctrl_en_clr", 2'd0, 32'h8);
        irq_chk("os_irq_held", 1'b1);
        tick();
        irq_chk("os_irq_held2", 1'b1);
        wr(2'd0, 32'h8);
        irq_chk("os_irq_ack", 1'b0);
        rd_chk("os_ctrl_after_ack", 2'd0, 32'h8);

        // Auto-reload, PRESET=3
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
`ifdef TIMER_AUTO_RELOAD_EN
        rd_chk("ar_ctrl", 2'd0, 32'hB);
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            int k;
            k = i % 5;
            rd_chk("ar_count", 2'd2, (k < 3) ? 32'(3 - k) : 32'd0);
            irq_chk("ar_irq", k == 3);
            tick();
        end
        wr(2'd0, 32'h0);
        tick();
`else
        rd_chk("nar_ctrl", 2'd0, 32'h9);
        tick(); tick();
        for (int v = 3; v >= 1; v--) begin
            rd_chk("nar_count", 2'd2, v[31:0]);
            irq_chk("nar_irq_low", 1'b0);
            tick();
        end
        rd_chk("nar_count0", 2'd2, 32'd0);
        irq_chk("nar_irq_rise", 1'b1);
        tick();
        rd_chk("nar_ctrl_en_clr", 2'd0, 32'h8);
        tick();
        rd_chk("nar_no_reload", 2'd2, 32'd0);
        irq_chk("nar_irq_held", 1'b1);
        wr(2'd0, 32'h0);
        tick();
`endif

        // Mid-count disable freezes COUNT; re-enable reloads PRESET
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        wait_count(32'd11);
        wr(2'd0, 32'h8);               // last decrement lands on this edge
        rd_chk("frz_count_a", 2'd2, 32'd10);
        tick();
        rd_chk("frz_count_b", 2'd2, 32'd10);
        tick();
        rd_chk("frz_count_c", 2'd2, 32'd10);
        wr(2'd2, 32'hFFFF);
        wr(2'd3, 32'h1234);
        rd_chk("ro_count", 2'd2, 32'd10);
        rd_chk("ro_addr3", 2'd3, 32'd0);
        rd_chk("ro_preset", 2'd1, 32'd20);
        wr(2'd0, 32'h9);
        tick();                        // LOAD
        rd_chk("reen_pre_load", 2'd2, 32'd10);
        tick();
        rd_chk("reen_reload", 2'd2, 32'd20);
        wr(2'd1, 32'd50);              // PRESET write during CNT
        rd_chk("preset_defer", 2'd2, 32'd19);
        rd_chk("preset_stored", 2'd1, 32'd50);
        wr(2'd0, 32'h8);
        tick();

        // PRESET=0, IM=0: expiry sets the flag but IRQ is masked
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        tick(); tick(); tick();        // LOAD, CNT, expire -> INT
        rd_chk("z_count", 2'd2, 32'd0);
        irq_chk("z_irq_masked", 1'b0);
        tick();
        rd_chk("z_ctrl_en_clr", 2'd0, 32'h0);
        wr(2'd0, 32'h9);               // unmask, but write clears the flag
        irq_chk("z_irq_cleared", 1'b0);
        tick(); tick(); tick();        // runs again and expires with IM=1
        irq_chk("z_irq_rerun", 1'b1);
        tick();

        // CTRL write on the same edge as the hardware EN clear wins
        wr(2'd1, 32'd1);
        irq_chk("race_preset_ack", 1'b0);
        wr(2'd0, 32'h9);
        tick(); tick(); tick();        // LOAD, CNT(1), expire -> INT
        irq_chk("race_irq", 1'b1);
        wr(2'd0, 32'h9);               // lands while in INT
        rd_chk("race_ctrl_kept", 2'd0, 32'h9);
        irq_chk("race_irq_ack", 1'b0);
        tick(); tick();
        rd_chk("race_restart", 2'd2, 32'd1);
        wr(2'd0, 32'h0);
        tick();

        // Reset mid-count, with a concurrent write that must lose
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        wait_count(32'd7);
        reset = 1'b1;
        WE    = 1'b1;
        Addr  = 2'd1;
        Din   = 32'd55;
        tick();
        WE    = 1'b0;
        reset = 1'b0;
        rd_chk("mrst_ctrl",   2'd0, 32'd0);
        rd_chk("mrst_preset", 2'd1, 32'd0);
        rd_chk("mrst_count",  2'd2, 32'd0);
        irq_chk("mrst_irq", 1'b0);
        tick(); tick();
        rd_chk("mrst_idle", 2'd2, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_device.md
TIMER_DEVICE -- requirements
Module: timer_device

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port Addr, input, 2 bits: word offset within the device (0 CTRL, 1 PRESET, 2 COUNT, 3 unused).
REQ-004 The block SHALL have port WE, input, 1 bit: processor write enable for the register at Addr.
REQ-005 The block SHALL have port Din, input, 32 bits: processor write data.
REQ-006 The block SHALL have port Dout, output, 32 bits: combinational read data for the register at Addr.
REQ-007 The block SHALL have port IRQ, output, 1 bit: interrupt request, wired to one HWInt bit of the coprocessor.

Function
REQ-008 CTRL fields SHALL be: [0] EN (count enable); [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00); [3] IM (interrupt mask, 1 = IRQ allowed); [31:4] read as 0 and are not stored.
REQ-009 PRESET SHALL be 32-bit read/write; COUNT SHALL be 32-bit read-only, with writes to Addr 2 or 3 ignored.
REQ-010 Dout SHALL be CTRL, PRESET or COUNT for Addr 0, 1 or 2, and 0 for Addr 3.
REQ-011 The state machine SHALL have states IDLE, LOAD, CNT, INT.
REQ-012 IDLE: COUNT held; EN=1 -> LOAD next cycle.
REQ-013 LOAD: COUNT <= PRESET; -> CNT.
REQ-014 CNT: EN=0 -> IDLE with COUNT frozen; else COUNT > 1 -> COUNT-1 and stay; else (COUNT 1 or 0) -> COUNT <= 0, irq_flag <= 1, -> INT.
REQ-015 INT, MODE=00: hardware SHALL clear CTRL.EN, keep irq_flag=1, and go -> IDLE.
REQ-016 INT, MODE=01: irq_flag SHALL clear on leaving INT (one-cycle pulse) and the state SHALL go -> LOAD; EN is not cleared.
REQ-017 A processor write to CTRL or PRESET SHALL clear irq_flag in the same edge.
REQ-018 IRQ SHALL equal irq_flag AND CTRL.IM, registered-output timing only (no combinational path from Din/WE).
REQ-019 A processor CTRL write in the same cycle as the hardware EN clear SHALL win: the written value is stored.
REQ-020 A PRESET write while in CNT SHALL take effect only at the next LOAD.
REQ-021 The decrement SHALL be unsigned 32-bit; COUNT never wraps below 0.
REQ-022 Latency from EN write to first decrement SHALL be 3 edges: IDLE->LOAD, LOAD->CNT, first decrement.

Reset
REQ-023 When reset is sampled high, CTRL, PRESET, COUNT and irq_flag SHALL be 0 and the state SHALL be IDLE; IRQ=0 and Dout reflects the zeroed registers.
REQ-024 Reset SHALL take priority over WE and all state transitions, including mid-count and in INT.

Configuration
REQ-025 The macro TIMER_AUTO_RELOAD_EN SHALL control auto-reload support.
REQ-026 With TIMER_AUTO_RELOAD_EN defined, MODE behaves per REQ-015/016.
REQ-027 Without TIMER_AUTO_RELOAD_EN, CTRL[2:1] SHALL not be stored, SHALL read as 0, and every expiry SHALL follow one-shot behaviour (REQ-015).

Verification
REQ-028 Reset, read Addr 0/1/2/3 -> Dout all 0; IRQ=0.
REQ-029 PRESET=5, CTRL=0x9 (EN, IM, one-shot) -> COUNT 5,4,3,2,1,0; IRQ rises the edge COUNT reaches 0; CTRL reads 0x8; IRQ held until a CTRL write of 0x8 clears it.
REQ-030 PRESET=3, CTRL=0xB (auto-reload) -> IRQ one-cycle pulse every 5 cycles (3 decrement cycles + INT + LOAD); COUNT reloads to 3 each period.
REQ-031 Mid-count (COUNT=10), write CTRL=0x8 -> next cycle IDLE, COUNT stays 10; write CTRL=0x9 -> LOAD reloads PRESET, not 10.
REQ-032 PRESET=0, CTRL=0x1 (IM=0) -> expires after the first CNT cycle; irq_flag set, but IRQ stays 0; write CTRL=0x9 -> IRQ still 0 (flag cleared by write).
REQ-033 Assert reset while in CNT with COUNT=7 -> next edge all registers 0, state IDLE, IRQ 0; build without TIMER_AUTO_RELOAD_EN, CTRL=0xB -> reads 0x9, behaves one-shot.
